// File: rtl/cla_pkg.sv
// Shared definitions for the serial wide adder: slice width, FSM state
// encoding and a constant-evaluable ceil(log2) for counter sizing.
package cla_pkg;

  localparam int SLICE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_serial_wide_adder_if.sv
// Operand/result handshake bundle for the serial wide adder.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds valid and its data stable until that edge, ready never waits on valid.
interface cla_serial_wide_adder_if #(
  parameter int NWORD = 4
);
  import cla_pkg::*;

  localparam int W = SLICE_W * NWORD;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, c_out
  );

endinterface

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder with no carry-in; generate/propagate per bit.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       c_out
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum   = p ^ c[7:0];
  assign c_out = c[8];

endmodule

// File: rtl/cla_serial_wide_adder.sv
// Multi-cycle wide adder: one 8-bit CLA slice per clock, LSB first, with a
// registered inter-slice carry injected through a second cla_8bit stage.
module cla_serial_wide_adder
  import cla_pkg::*;
#(
  parameter int NWORD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cla_serial_wide_adder_if.slave  bus,
  output logic [1:0]              dbg_state
);

  localparam int W  = SLICE_W * NWORD;
  localparam int CW = (clog2(NWORD) < 1) ? 1 : clog2(NWORD);

  state_t                 state;
  state_t                 state_nx;
  logic [W-1:0]           a_sh;
  logic [W-1:0]           b_sh;
  logic [W-1:0]           sum_q;
  logic                   carry;
  logic                   c_out_q;
  logic [CW-1:0]          count;
  logic                   last;

  logic [SLICE_W-1:0]     s1;
  logic [SLICE_W-1:0]     s2;
  logic                   c1;
  logic                   c2;

  cla_8bit u_add (
    .a     (a_sh[SLICE_W-1:0]),
    .b     (b_sh[SLICE_W-1:0]),
    .sum   (s1),
    .c_out (c1)
  );

  // Carry injection: c1 and c2 are mutually exclusive, so OR gives the slice carry.
  cla_8bit u_inj (
    .a     (s1),
    .b     ({7'b0, carry}),
    .sum   (s2),
    .c_out (c2)
  );

  assign last = (count == CW'(NWORD - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.in_valid)  state_nx = S_RUN;
      S_RUN:   if (last)          state_nx = S_DONE;
      S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
      default:                    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      c_out_q <= 1'b0;
      count   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= 1'b0;
            count <= '0;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> SLICE_W;
          b_sh  <= b_sh >> SLICE_W;
          // Slices enter at the top so slice 0 lands at the bottom after NWORD steps.
          sum_q <= {s2, sum_q[W-1:SLICE_W]};
          carry <= c1 | c2;
          if (last) begin
            c_out_q <= c1 | c2;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_cla_serial_wide_adder.sv
// Bench for cla_serial_wide_adder: vector table plus hand-written
// hold, ignored-input and mid-operation reset sequences.
module tb_cla_serial_wide_adder;
  import cla_pkg::*;

  localparam int NWORD = 4;
  localparam int W     = 8 * NWORD;
  localparam int NVEC  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  cla_serial_wide_adder_if #(.NWORD(NWORD)) bus ();

  cla_serial_wide_adder #(.NWORD(NWORD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         c;
  } vec_t;

  vec_t       vecs [NVEC];
  logic [W:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, then presents one operand pair for exactly one edge.
  task automatic accept_only(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  // Accepts a pair, records its expected result, and measures edges to out_valid.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] esum, input logic ec, input bit glitch);
    int lat = 0;
    accept_only(a, b);
    exp_q.push_back({ec, esum});
    while (1) begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
      if (lat == 1) check("state_run", 64'(dbg_state), 64'(ST_RUN));
      if (glitch && lat == 1) begin
        bus.in_valid = 1'b1;
        bus.a        = ~a;
        bus.b        = ~b;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (lat > 50) break;
    end
    bus.in_valid = 1'b0;
    // Edges after the accepting edge; counting the accepting edge itself gives NWORD+1.
    check("latency", 64'(lat), 64'(NWORD));
  endtask

  // Compares the presented result, holds it off for `hold` cycles, then takes it.
  task automatic recv(input int hold);
    logic [W:0] got;
    logic [W:0] exp;
    got = {bus.c_out, bus.sum};
    if (exp_q.size() == 0) begin
      exp = 'x;
    end else begin
      exp = exp_q.pop_front();
    end
    check("result", 64'(got), 64'(exp));
    check("state_done", 64'(dbg_state), 64'(ST_DONE));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", 64'({bus.out_valid, bus.in_ready, bus.c_out, bus.sum}),
            64'({1'b1, 1'b0, got}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after", 64'(bus.in_ready), 64'd1);
    check("out_valid_after", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_sum"},       64'(bus.sum),       64'd0);
    check({tag, "_c_out"},     64'(bus.c_out),     64'd0);
    check({tag, "_state"},     64'(dbg_state),     64'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] model;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    vecs[0] = '{a: 32'h12345678, b: 32'h11111111, sum: 32'h23456789, c: 1'b0};
    vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h00000001, sum: 32'h00000000, c: 1'b1};
    vecs[2] = '{a: 32'h00FF00FF, b: 32'h00010001, sum: 32'h01000100, c: 1'b0};
    vecs[3] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, sum: 32'hFFFFFFFE, c: 1'b1};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].a = $urandom;
      vecs[i].b = $urandom;
      model     = {1'b0, vecs[i].a} + {1'b0, vecs[i].b};
      vecs[i].sum = model[W-1:0];
      vecs[i].c   = model[W];
    end

    // Vector 0 is held off for 3 cycles; vector 2 sees an in_valid pulse during RUN.
    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].c, (i == 2));
      recv((i == 0) ? 3 : 0);
    end

    // Reset after two RUN edges abandons the operation.
    accept_only(32'hDEADBEEF, 32'h01234567);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid_run");

    send(32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
    recv(0);

    // Reset while a result is waiting; reset wins over a same-cycle out_ready.
    send(32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid_done");

    send(32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0);
    recv(1);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
